// File: rtl/seven_seg_bank_if.sv
// seven_seg_bank_if: user-I/O side bus of the seven-segment bank
interface seven_seg_bank_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    iBtn;
  logic [1:0]              iMode;
  logic                    iLoad;
  logic [3:0]              iNum;
  logic [7*NUM_DIGITS-1:0] oHex;
  logic [NUM_DIGITS-1:0]   oHex_en;
  logic                    oBtnPulse;
  logic                    oAllDisabled;
  logic                    oAllEnabled;
  modport master (
    output iBtn, iMode, iLoad, iNum,
    input  oHex, oHex_en, oBtnPulse, oAllDisabled, oAllEnabled
  );
  modport slave (
    input  iBtn, iMode, iLoad, iNum,
    output oHex, oHex_en, oBtnPulse, oAllDisabled, oAllEnabled
  );
endinterface

// File: rtl/seven_seg_bank.sv
// seven_seg_bank: N-digit hex seven-segment bank with a debounced button editing the enable mask
module seven_seg_bank #(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int BLANK_DISABLED  = 1
) (
  input logic             iClk,
  input logic             iRst_n,
  seven_seg_bank_if.slave bus
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] INV = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [1:0]                 sync_q;
  logic                       s2;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       deb_q, deb_d, deb_prev_q, pulse_q;
  logic [NUM_DIGITS-1:0]      mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [7*NUM_DIGITS-1:0]    hex;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    return SEG_LUT[7*int'(v) +: 7] ^ INV;
  endfunction
  assign s2 = sync_q[1];
  always_comb begin
    cnt_d = ((s2 == deb_q) || (cnt_q == CNT_LAST)) ? '0 : cnt_q + 1'b1;
    deb_d = ((s2 != deb_q) && (cnt_q == CNT_LAST)) ? s2 : deb_q;
    mask_d = !pulse_q             ? mask_q :
             bus.iMode == 2'b00   ? {1'b0, mask_q[NUM_DIGITS-1:1]} :
             bus.iMode == 2'b01   ? {mask_q[NUM_DIGITS-2:0], 1'b1} :
             bus.iMode == 2'b11   ? mask_q :
             mask_q == '0         ? {{(NUM_DIGITS-1){1'b0}}, 1'b1} :
             {mask_q[NUM_DIGITS-2:0], mask_q[NUM_DIGITS-1]};
    dig_d = dig_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bus.iLoad && mask_q[k]) dig_d[k] = bus.iNum;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      mask_q     <= '1;
      dig_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], bus.iBtn};
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
      mask_q     <= mask_d;
      dig_q      <= dig_d;
    end
  end
  always_comb begin
    hex = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      hex[7*k +: 7] = (mask_q[k] || BLANK_DISABLED == 0) ? seg7(dig_q[k]) : INV;
  end
  assign bus.oHex         = hex;
  assign bus.oHex_en      = mask_q;
  assign bus.oBtnPulse    = pulse_q;
  assign bus.oAllDisabled = mask_q == '0;
  assign bus.oAllEnabled  = &mask_q;
endmodule

// File: doc/seven_seg_bank.md
Name: seven_seg_bank

Overview:
- Parametrised N-digit seven-segment display bank with a per-digit enable mask.
- Each digit latches a 4-bit hex value from a shared input bus and decodes it to segments.
- A debounced push-button edits the enable mask in one of four run-time modes.
- Sits between the user I/O layer (switches, keys) and the board 7-segment pins.

Parameters:
- NUM_DIGITS, 6, number of digits; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a button change; >= 1.
- SEG_ACTIVE_LOW, 1, 1 inverts every segment output (lit = 0).
- BLANK_DISABLED, 1, 1: a disabled digit shows all segments off; 0: a disabled digit shows its last held value.

Ports:
- iClk, input, 1, clock.
- iRst_n, input, 1, reset, asynchronous, active-low.
- iBtn, input, 1, raw asynchronous push-button, active-high.
- iMode, input, 2, mask edit mode, sampled on the press-pulse cycle.
- iLoad, input, 1, capture iNum into every enabled digit.
- iNum, input, 4, hex value 0-F.
- oHex, output, 7*NUM_DIGITS, segments; digit i at bits [7i+6:7i]; bit order a..g = bit0..bit6.
- oHex_en, output, NUM_DIGITS, current enable mask.
- oBtnPulse, output, 1, one-cycle debounced press strobe.
- oAllDisabled, output, 1, mask == 0.
- oAllEnabled, output, 1, mask all ones.

Behaviour:
- Reset (asynchronous):
  - mask = all ones; all digit registers = 0.
  - Synchroniser, debounced level, debounce counter and oBtnPulse = 0.
  - oHex shows "0" on every digit: 7'h40 each when SEG_ACTIVE_LOW=1, 7'h3F when 0.
  - Reset mid-debounce or mid-press discards all progress.
- Button path:
  - iBtn passes through a 2-flop synchroniser (s2 = its output).
  - Counter rule:
    - s2 == debounced level: counter cleared.
    - s2 differs and counter == DEBOUNCE_CYCLES-1: debounced level <= s2, counter <= 0.
    - s2 differs otherwise: counter increments.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles are ignored.
  - oBtnPulse = debounced & ~debounced_prev (registered): high exactly one cycle per press, never on release.
  - Latency with D=4: iBtn rises before edge 1 -> debounced level set at edge 6 -> oBtnPulse high between edges 7 and 8 -> mask updates at edge 8.
  - Holding the button produces no repeat pulse.
- Mask update, applied on the edge where oBtnPulse = 1, using iMode at that edge:
  - 00 SHIFT_OFF: mask <= {1'b0, mask[N-1:1]}; all-zero stays zero.
  - 01 SHIFT_ON: mask <= {mask[N-2:0], 1'b1}; all-ones stays all-ones.
  - 10 ROTATE: if mask == 0, mask <= 1; else mask <= {mask[N-2:0], mask[N-1]}.
  - 11 HOLD: mask unchanged.
  - Mode changes on non-pulse cycles have no effect.
- Digit load:
  - On each edge with iLoad = 1, digit i <= iNum for every i with mask[i] = 1 (mask value before that edge).
  - Load and press on the same edge: the load uses the old mask; the mask updates simultaneously.
  - iLoad held high re-captures every cycle.
- Output decode:
  - oHex is combinational from registers only; no combinational path from any input.
  - A load becomes visible on oHex in the cycle after the capturing edge.
  - Active-high patterns, hex digit -> g..a:
    - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
    - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - SEG_ACTIVE_LOW=1 inverts all 7 bits.
  - Disabled digit with BLANK_DISABLED=1: all segments off (7'h7F active-low, 7'h00 active-high).
  - Disabled digit with BLANK_DISABLED=0: decoded held value.
- oAllDisabled and oAllEnabled are combinational from the mask.

Test Plan:
- Reset then idle, defaults -> oHex = 42'h40 in every 7-bit slot; oHex_en = 6'b111111; oAllEnabled = 1.
- iBtn high for 2 synchronised cycles, D=4 -> no oBtnPulse, mask unchanged.
- Mode 00, six clean presses -> mask 011111, 001111 ... 000000; oAllDisabled = 1 after the 6th; a 7th press keeps 000000.
- From 000011: iNum = A with iLoad for 1 cycle -> digits 0-1 = 7'h08 (active-low A); digits 2-5 = 7'h7F (blank); switch to BLANK_DISABLED=0 -> digits 2-5 show prior values.
- Mode 10 from 000000: 3 presses -> mask 000001, 000010, 000100; mode 01 press -> 001001.
- iLoad and press on the same edge, mode 00 from 111111, iNum = 5 -> all six digits load 5 (6'h12 active-low); mask becomes 011111; digit 5 then blanks.
- Assert iRst_n low mid-debounce (counter = 2) -> no pulse after release of reset; mask = all ones.
